// File: rtl/cpu_result_monitor.sv
// cpu_result_monitor: timed run that logs per-channel changes of ch_data as {mask,data,time} events in a show-ahead FIFO (in: clk, rst, start, ch_data, rd_en; out: ev_valid, ev_mask, ev_data, ev_time, ev_count, overflow, busy, done, timeout)
module cpu_result_monitor #(
  parameter int CH = 4,
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int QUIET = 64,
  parameter int MAX_CYC = 200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CH*W-1:0]            ch_data,
  input  logic                       rd_en,
  output logic                       ev_valid,
  output logic [CH-1:0]              ev_mask,
  output logic [CH*W-1:0]            ev_data,
  output logic [15:0]                ev_time,
  output logic [$clog2(DEPTH):0]     ev_count,
  output logic                       overflow,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = CH + CH*W + 16;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [15:0] QT = 16'(QUIET);
  localparam logic [15:0] MC = 16'(MAX_CYC - 1);
  typedef enum logic [1:0] {IDLE, BASE, RUN, DONE} state_t;
  state_t state;
  logic [CH*W-1:0] prev;
  logic [15:0] cyc, quiet, quiet_nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CH-1:0] mask;
  logic push, pop, wr, quiet_end, cyc_end, go;
  for (genvar k = 0; k < CH; k++) begin : g_cmp
    assign mask[k] = ch_data[k*W +: W] != prev[k*W +: W];
  end
  assign go = (state == IDLE || state == DONE) && start;
  assign push = state == RUN && |mask;
  assign pop = rd_en && ev_valid;
  // a full FIFO still accepts the push when the head leaves in the same cycle
  assign wr = push && (ev_count != FULL || pop);
  assign quiet_nxt = |mask ? 16'd0 : quiet + 16'd1;
  assign quiet_end = quiet_nxt == QT;
  assign cyc_end = cyc == MC;
  assign ev_valid = ev_count != '0;
  assign head = mem[rd_ptr];
  assign ev_mask = ev_valid ? head[EW-1 -: CH] : '0;
  assign ev_data = ev_valid ? head[CH*W+15:16] : '0;
  assign ev_time = ev_valid ? head[15:0] : '0;
  always_ff @(posedge clk)
    if (wr && !go && !rst) mem[wr_ptr] <= {mask, ch_data, cyc};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      overflow <= 1'b0;
      ev_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cyc <= '0;
      quiet <= '0;
      prev <= '0;
    end else if (go) begin
      state <= BASE;
      busy <= 1'b1;
      done <= 1'b0;
      timeout <= 1'b0;
      overflow <= 1'b0;
      ev_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cyc <= '0;
      quiet <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      ev_count <= ev_count + (AW+1)'(wr) - (AW+1)'(pop);
      if (push && !wr) overflow <= 1'b1;
      if (state == BASE) begin
        prev <= ch_data;
        cyc <= '0;
        state <= RUN;
      end
      if (state == RUN) begin
        cyc <= cyc + 16'd1;
        quiet <= quiet_nxt;
        if (|mask) prev <= ch_data;
        // a quiet exit wins over the hard limit when both land together
        if (quiet_end || cyc_end) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          timeout <= !quiet_end;
        end
      end
    end
  end
endmodule

// File: tb/tb_cpu_result_monitor.sv
// tb_cpu_result_monitor: randomized and directed bench with a queue-based reference model
module tb_cpu_result_monitor;
  localparam int CH = 4, W = 8, DEPTH = 16, QUIET = 64, MAX_CYC = 200;
  logic clk = 0, rst = 1, start = 0, rd_en = 0;
  logic [CH*W-1:0] ch_data = '0;
  logic ev_valid, overflow, busy, done, timeout;
  logic [CH-1:0] ev_mask;
  logic [CH*W-1:0] ev_data;
  logic [15:0] ev_time;
  logic [$clog2(DEPTH):0] ev_count;
  cpu_result_monitor #(.CH(CH), .W(W), .DEPTH(DEPTH), .QUIET(QUIET), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_data(ch_data), .rd_en(rd_en),
    .ev_valid(ev_valid), .ev_mask(ev_mask), .ev_data(ev_data), .ev_time(ev_time),
    .ev_count(ev_count), .overflow(overflow), .busy(busy), .done(done), .timeout(timeout)
  );
  always #5 clk = ~clk;
  typedef struct {logic [CH-1:0] m; logic [CH*W-1:0] d; logic [15:0] t;} ent_t;
  ent_t q[$];
  int ph = 0;
  int m_cyc = 0, m_quiet = 0;
  bit m_ovf = 0, m_to = 0;
  logic [CH*W-1:0] m_prev = '0;
  logic [CH-1:0] chg;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      ph = 0; m_ovf = 0; m_to = 0; m_prev = '0; m_cyc = 0; m_quiet = 0;
    end else if ((ph == 0 || ph == 3) && start) begin
      q.delete();
      ph = 1; m_ovf = 0; m_to = 0;
    end else begin
      for (int k = 0; k < CH; k++) chg[k] = ch_data[k*W +: W] != m_prev[k*W +: W];
      if (rd_en && q.size() > 0) void'(q.pop_front());
      if (ph == 1) begin
        m_prev = ch_data; m_cyc = 0; m_quiet = 0; ph = 2;
      end else if (ph == 2) begin
        if (chg != 0) begin
          if (q.size() < DEPTH) q.push_back('{chg, ch_data, 16'(m_cyc)});
          else m_ovf = 1;
          m_prev = ch_data;
        end
        m_quiet = chg != 0 ? 0 : m_quiet + 1;
        if (m_quiet == QUIET) begin ph = 3; m_to = 0; end
        else if (m_cyc == MAX_CYC - 1) begin ph = 3; m_to = 1; end
        m_cyc++;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("ev_count", ev_count, q.size());
    chk("ev_valid", ev_valid, q.size() > 0);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, ph == 1 || ph == 2);
    chk("done", done, ph == 3);
    chk("timeout", timeout, m_to);
    if (q.size() > 0) begin
      chk("ev_mask", ev_mask, q[0].m);
      chk("ev_data", ev_data, q[0].d);
      chk("ev_time", ev_time, q[0].t);
    end
  end
  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  initial begin
    int t;
    int rdp, cdiv;
    start = 1;
    tick(1);
    chk_en = 1;
    tick(1);
    rst = 0; start = 0;
    tick(1);
    chk("rst_busy", busy, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_valid", ev_valid, 0);
    ch_data = '0; start = 1;
    tick(1);
    start = 0;
    tick(4);
    ch_data[7:0] = 8'h05;
    tick(4);
    ch_data[31:16] = 16'h3344;
    tick(1);
    t = 1;
    while (!done && t < 300) begin tick(1); t++; end
    chk("quiet_len", t, 65);
    chk("quiet_done", done, 1);
    chk("quiet_to", timeout, 0);
    chk("two_ev", ev_count, 2);
    chk("ev1_mask", ev_mask, 4'b0001);
    chk("ev1_time", ev_time, 3);
    chk("ev1_data", ev_data, 32'h00000005);
    rd_en = 1;
    tick(1);
    chk("ev2_mask", ev_mask, 4'b1100);
    chk("ev2_time", ev_time, 7);
    chk("ev2_data", ev_data, 32'h33440005);
    tick(1);
    chk("drained", ev_valid, 0);
    start = 1;
    tick(1);
    start = 0; t = 0;
    while (!done && t < 400) begin ch_data[15:8] = ~ch_data[15:8]; tick(1); t++; end
    rd_en = 0;
    chk("lim_done", done, 1);
    chk("lim_to", timeout, 1);
    chk("lim_time", ev_time, 199);
    chk("lim_mask", ev_mask, 4'b0010);
    ch_data = '0; start = 1;
    tick(1);
    start = 0;
    tick(1);
    for (int i = 0; i < 20; i++) begin ch_data[7:0] = 8'(i + 1); tick(1); end
    chk("full_count", ev_count, 16);
    chk("full_ovf", overflow, 1);
    chk("full_head", ev_time, 0);
    ch_data[7:0] = 8'd100; rd_en = 1;
    tick(1);
    rd_en = 0;
    chk("fullpop_count", ev_count, 16);
    chk("fullpop_head", ev_time, 1);
    rst = 1;
    tick(1);
    rst = 0; ch_data = '0; start = 1;
    tick(1);
    start = 0;
    tick(1);
    for (int i = 0; i < 5; i++) begin ch_data[15:8] = 8'(i + 1); tick(1); end
    chk("five_count", ev_count, 5);
    rst = 1;
    tick(1);
    rst = 0;
    chk("midrst_count", ev_count, 0);
    chk("midrst_busy", busy, 0);
    ch_data = 32'hdeadbeef; start = 1;
    tick(1);
    start = 0;
    tick(10);
    chk("nospur_count", ev_count, 0);
    chk("nospur_busy", busy, 1);
    for (int n = 0; n < 20000; n++) begin
      if (n % 2000 == 0) begin
        rdp = $urandom_range(0, 100);
        cdiv = (n / 2000) % 3 == 0 ? 3 : ((n / 2000) % 3 == 1 ? 40 : 200);
      end
      rst = $urandom_range(0, 999) == 0;
      start = $urandom_range(0, 29) == 0;
      rd_en = $urandom_range(0, 99) < rdp;
      if ($urandom_range(0, cdiv - 1) == 0)
        for (int k = 0; k < CH; k++) if ($urandom_range(0, 1) == 1) ch_data[k*W +: W] = 8'($urandom);
      tick(1);
    end
    rst = 0; start = 0; rd_en = 0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
